// File: rtl/bitstream_tx.sv
// bitstream_tx: serialises parallel AXI-stream words into a one-bit AXI-stream.
// A word is held in a shift register and emitted one bit per accepted beat.
// The next word can load on the same edge that the last bit of the current
// word leaves, so back-to-back words stream without a gap.
// bit_count counts accepted serial bits per frame and saturates; done pulses
// once after the frame's final bit.
module bitstream_tx #(
    parameter int IN_WIDTH  = 8,
    parameter int MSB_FIRST = 1,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [IN_WIDTH-1:0]  s_tdata,
    input  logic                 s_tvalid,
    input  logic                 s_tlast,
    output logic                 s_tready,
    output logic                 m_tdata,
    output logic                 m_tvalid,
    output logic                 m_tlast,
    input  logic                 m_tready,
    output logic [CNT_WIDTH-1:0] bit_count,
    output logic                 done
);

    localparam int                   IDX_W    = (IN_WIDTH > 1) ? $clog2(IN_WIDTH) : 1;
    localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(IN_WIDTH - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t              state;
    state_t              state_next;

    logic [IN_WIDTH-1:0] shreg;
    logic [IDX_W-1:0]    bit_idx;
    logic                held_last;
    // Set when the next accepted serial bit starts a fresh frame.
    logic                frame_start;

    logic                final_bit;
    logic                bit_accept;
    logic                word_accept;

    // Counter increment that sticks at the all-ones value.
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    // Move the held word one position toward the bit that is presented next.
    function automatic logic [IN_WIDTH-1:0] shift_out(input logic [IN_WIDTH-1:0] v);
        return (MSB_FIRST != 0) ? (v << 1) : (v >> 1);
    endfunction

    assign final_bit = (bit_idx == LAST_IDX);
    assign m_tdata   = (MSB_FIRST != 0) ? shreg[IN_WIDTH-1] : shreg[0];

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state, handshake outputs and transfer strobes.
    always_comb begin
        state_next  = state;
        m_tvalid    = 1'b0;
        m_tlast     = 1'b0;
        s_tready    = 1'b0;
        bit_accept  = 1'b0;
        word_accept = 1'b0;
        case (state)
            IDLE: begin
                s_tready    = !rst;
                word_accept = s_tvalid && !rst;
                if (word_accept) begin
                    state_next = SEND;
                end
            end
            SEND: begin
                m_tvalid    = 1'b1;
                m_tlast     = held_last && final_bit;
                bit_accept  = m_tready;
                // Ready for a new word only as the held word's last bit leaves,
                // which lets the refill happen without a bubble.
                s_tready    = !rst && m_tready && final_bit;
                word_accept = s_tvalid && s_tready;
                if (bit_accept && final_bit && !word_accept) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Shift register, bit index and frame-end flag of the held word.
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg     <= '0;
            bit_idx   <= '0;
            held_last <= 1'b0;
        end else if (word_accept) begin
            shreg     <= s_tdata;
            bit_idx   <= '0;
            held_last <= s_tlast;
        end else if (bit_accept) begin
            shreg     <= shift_out(shreg);
            bit_idx   <= bit_idx + 1'b1;
        end
    end

    // Per-frame bit counter and end-of-frame pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_count   <= '0;
            frame_start <= 1'b1;
            done        <= 1'b0;
        end else begin
            done <= bit_accept && m_tlast;
            if (bit_accept) begin
                bit_count   <= frame_start ? CNT_WIDTH'(1) : sat_inc(bit_count);
                frame_start <= m_tlast;
            end
        end
    end

endmodule

// File: tb/tb_bitstream_tx.sv
// Testbench for bitstream_tx: three instances (MSB-first, LSB-first, 4-bit
// counter) checked every cycle against a queue-of-bits model, plus literal
// expectations for the directed scenarios.
module tb_bitstream_tx;

    logic       clk;
    logic       rst;
    logic [7:0] s_tdata [3];
    logic [2:0] s_tvalid;
    logic [2:0] s_tlast;
    logic [2:0] s_tready;
    logic [2:0] m_tdata;
    logic [2:0] m_tvalid;
    logic [2:0] m_tlast;
    logic [2:0] m_tready;
    logic [2:0] done;
    logic [15:0] bc0;
    logic [15:0] bc1;
    logic [3:0]  bc2;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit armed = 0;

    // model state: pending serial bits of each instance
    logic qb [3][64];
    logic ql [3][64];
    int   qn [3];
    int   ecnt [3];
    bit   enew [3];
    bit   edone [3];

    // log of bits the DUTs actually delivered
    logic lbits [3][256];
    logic llast [3][256];
    int   lcyc  [3][256];
    int   ln    [3];
    int   ldone [3];
    int   ldcyc [3];

    bitstream_tx #(.IN_WIDTH(8), .MSB_FIRST(1), .CNT_WIDTH(16)) u_msb (
        .clk(clk), .rst(rst), .s_tdata(s_tdata[0]), .s_tvalid(s_tvalid[0]),
        .s_tlast(s_tlast[0]), .s_tready(s_tready[0]), .m_tdata(m_tdata[0]),
        .m_tvalid(m_tvalid[0]), .m_tlast(m_tlast[0]), .m_tready(m_tready[0]),
        .bit_count(bc0), .done(done[0]));

    bitstream_tx #(.IN_WIDTH(8), .MSB_FIRST(0), .CNT_WIDTH(16)) u_lsb (
        .clk(clk), .rst(rst), .s_tdata(s_tdata[1]), .s_tvalid(s_tvalid[1]),
        .s_tlast(s_tlast[1]), .s_tready(s_tready[1]), .m_tdata(m_tdata[1]),
        .m_tvalid(m_tvalid[1]), .m_tlast(m_tlast[1]), .m_tready(m_tready[1]),
        .bit_count(bc1), .done(done[1]));

    bitstream_tx #(.IN_WIDTH(8), .MSB_FIRST(1), .CNT_WIDTH(4)) u_cnt4 (
        .clk(clk), .rst(rst), .s_tdata(s_tdata[2]), .s_tvalid(s_tvalid[2]),
        .s_tlast(s_tlast[2]), .s_tready(s_tready[2]), .m_tdata(m_tdata[2]),
        .m_tvalid(m_tvalid[2]), .m_tlast(m_tlast[2]), .m_tready(m_tready[2]),
        .bit_count(bc2), .done(done[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int msbf(input int i);
        return (i == 1) ? 0 : 1;
    endfunction

    function automatic int cmax(input int i);
        return (i == 2) ? 15 : 65535;
    endfunction

    function automatic logic [15:0] bc(input int i);
        case (i)
            0:       return bc0;
            1:       return bc1;
            default: return {12'd0, bc2};
        endcase
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    // Compare all DUTs against the model, log delivered bits, then advance
    // the model with the inputs that will be sampled at the coming edge.
    task automatic model_cycle();
        for (int i = 0; i < 3; i++) begin
            bit         exp_v;
            bit         exp_rdy;
            bit         lastb;
            logic [7:0] d;
            exp_v   = (qn[i] > 0);
            exp_rdy = !rst && (qn[i] == 0 || (qn[i] == 1 && m_tready[i]));
            if (armed) begin
                chk($sformatf("m_tvalid%0d", i), m_tvalid[i], exp_v);
                if (exp_v) begin
                    chk($sformatf("m_tdata%0d", i), m_tdata[i], qb[i][0]);
                    chk($sformatf("m_tlast%0d", i), m_tlast[i], ql[i][0]);
                end
                chk($sformatf("s_tready%0d", i), s_tready[i], exp_rdy);
                chk($sformatf("done%0d", i), done[i], edone[i]);
                chk($sformatf("bit_count%0d", i), bc(i), ecnt[i]);
                if (!rst && m_tvalid[i] && m_tready[i] && ln[i] < 256) begin
                    lbits[i][ln[i]] = m_tdata[i];
                    llast[i][ln[i]] = m_tlast[i];
                    lcyc[i][ln[i]]  = cyc;
                    ln[i]++;
                end
                if (done[i] === 1'b1) begin
                    ldone[i]++;
                    ldcyc[i] = cyc;
                end
            end
            if (rst) begin
                qn[i]    = 0;
                ecnt[i]  = 0;
                enew[i]  = 1'b1;
                edone[i] = 1'b0;
            end else begin
                edone[i] = 1'b0;
                if (exp_v && m_tready[i]) begin
                    lastb = ql[i][0];
                    for (int k = 0; k < qn[i] - 1; k++) begin
                        qb[i][k] = qb[i][k+1];
                        ql[i][k] = ql[i][k+1];
                    end
                    qn[i]--;
                    if (enew[i]) ecnt[i] = 1;
                    else if (ecnt[i] < cmax(i)) ecnt[i] = ecnt[i] + 1;
                    enew[i]  = lastb;
                    edone[i] = lastb;
                end
                if (s_tvalid[i] && exp_rdy) begin
                    d = s_tdata[i];
                    for (int k = 0; k < 8; k++) begin
                        qb[i][qn[i]] = (msbf(i) != 0) ? d[7-k] : d[k];
                        ql[i][qn[i]] = s_tlast[i] && (k == 7);
                        qn[i]++;
                    end
                end
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        model_cycle();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic send_word(input int i, input logic [7:0] d, input logic l, output int waited);
        s_tdata[i]  = d;
        s_tvalid[i] = 1'b1;
        s_tlast[i]  = l;
        waited = 0;
        #1;
        while (!s_tready[i] && waited < 40) begin
            tick();
            waited++;
            #1;
        end
        chk($sformatf("send_ready%0d", i), s_tready[i], 1'b1);
        tick();
        s_tvalid[i] = 1'b0;
        s_tlast[i]  = 1'b0;
    endtask

    task automatic drain(input int i);
        int n;
        n = 0;
        while (m_tvalid[i] && n < 60) begin
            tick();
            n++;
        end
        chk($sformatf("drain%0d", i), m_tvalid[i], 1'b0);
        tick();
    endtask

    function automatic logic [63:0] bits_from(input int i, input int s, input int n);
        logic [63:0] v;
        v = '0;
        for (int k = s; k < s + n; k++) v = {v[62:0], lbits[i][k]};
        return v;
    endfunction

    task automatic last_info(input int i, input int s, output int cnt, output int pos);
        cnt = 0;
        pos = -1;
        for (int k = s; k < ln[i]; k++) begin
            if (llast[i][k]) begin
                cnt++;
                pos = k - s;
            end
        end
    endtask

    initial begin
        int s0;
        int d0;
        int w;
        int lc;
        int lp;
        for (int i = 0; i < 3; i++) begin
            s_tdata[i] = 8'h00;
            qn[i] = 0; ecnt[i] = 0; enew[i] = 1'b1; edone[i] = 1'b0;
            ln[i] = 0; ldone[i] = 0; ldcyc[i] = 0;
        end
        s_tvalid = '0;
        s_tlast  = '0;
        m_tready = '1;
        rst      = 1'b1;
        tick();
        tick();
        chk("rst_s_tready", s_tready[0], 1'b0);
        armed = 1'b1;
        rst = 1'b0;
        #1;
        chk("post_rst_s_tready", s_tready[0], 1'b1);
        chk("post_rst_m_tvalid", m_tvalid[0], 1'b0);
        chk("post_rst_m_tdata", m_tdata[0], 1'b0);
        chk("post_rst_m_tlast", m_tlast[0], 1'b0);
        chk("post_rst_done", done[0], 1'b0);
        chk("post_rst_count", bc(0), 0);

        // single word 0xA5, sink always ready
        s0 = ln[0]; d0 = ldone[0];
        send_word(0, 8'hA5, 1'b1, w);
        drain(0);
        chk("a5_nbits", ln[0] - s0, 8);
        chk("a5_bits", bits_from(0, s0, 8), 64'hA5);
        last_info(0, s0, lc, lp);
        chk("a5_last_cnt", lc, 1);
        chk("a5_last_pos", lp, 7);
        chk("a5_done_cnt", ldone[0] - d0, 1);
        chk("a5_done_cyc", ldcyc[0] - lcyc[0][s0+7], 1);
        chk("a5_count", bc(0), 8);

        // back-to-back 0x0F then 0xF0
        s0 = ln[0]; d0 = ldone[0];
        send_word(0, 8'h0F, 1'b0, w);
        send_word(0, 8'hF0, 1'b1, w);
        chk("b2b_wait", w, 7);
        drain(0);
        chk("b2b_nbits", ln[0] - s0, 16);
        chk("b2b_bits", bits_from(0, s0, 16), 64'h0FF0);
        chk("b2b_span", lcyc[0][s0+15] - lcyc[0][s0], 15);
        last_info(0, s0, lc, lp);
        chk("b2b_last_pos", lp, 15);
        chk("b2b_done_cnt", ldone[0] - d0, 1);
        chk("b2b_count", bc(0), 16);

        // 0xA5 with sink ready alternating 1,0
        s0 = ln[0]; d0 = ldone[0];
        send_word(0, 8'hA5, 1'b1, w);
        for (int c = 0; c < 18; c++) begin
            m_tready[0] = (c % 2 == 0);
            tick();
        end
        m_tready[0] = 1'b1;
        drain(0);
        chk("stall_nbits", ln[0] - s0, 8);
        chk("stall_bits", bits_from(0, s0, 8), 64'hA5);
        chk("stall_span", lcyc[0][s0+7] - lcyc[0][s0], 14);
        last_info(0, s0, lc, lp);
        chk("stall_last_pos", lp, 7);
        chk("stall_done_cnt", ldone[0] - d0, 1);

        // LSB-first instance, word 0x01
        s0 = ln[1]; d0 = ldone[1];
        send_word(1, 8'h01, 1'b1, w);
        drain(1);
        chk("lsb_bits", bits_from(1, s0, 8), 64'h80);
        last_info(1, s0, lc, lp);
        chk("lsb_last_pos", lp, 7);
        chk("lsb_done_cnt", ldone[1] - d0, 1);
        chk("lsb_count", bc(1), 8);

        // reset after three bits of a frame
        s0 = ln[0]; d0 = ldone[0];
        send_word(0, 8'hA5, 1'b1, w);
        tick(); tick(); tick();
        chk("abort_nbits", ln[0] - s0, 3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("abort_m_tvalid", m_tvalid[0], 1'b0);
        chk("abort_count", bc(0), 0);
        chk("abort_done", done[0], 1'b0);
        chk("abort_s_tready", s_tready[0], 1'b1);
        repeat (12) tick();
        last_info(0, s0, lc, lp);
        chk("abort_no_last", lc, 0);
        chk("abort_no_done", ldone[0] - d0, 0);

        // 4-bit counter: saturation, hold after tlast, restart at 1
        d0 = ldone[2];
        send_word(2, 8'h3C, 1'b0, w);
        send_word(2, 8'hC3, 1'b0, w);
        send_word(2, 8'h55, 1'b0, w);
        chk("sat_no_done", ldone[2] - d0, 0);
        send_word(2, 8'hAA, 1'b1, w);
        drain(2);
        chk("sat_count", bc(2), 15);
        chk("sat_done_cnt", ldone[2] - d0, 1);
        send_word(2, 8'h81, 1'b1, w);
        chk("sat_hold", bc(2), 15);
        tick();
        chk("sat_restart", bc(2), 1);
        drain(2);
        chk("sat_next_frame", bc(2), 8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bitstream_tx.md
BITSTREAM_TX -- requirements
Module: bitstream_tx

Interface
REQ-001 Parameter IN_WIDTH, default 8, word width of the parallel input stream.
REQ-002 Parameter MSB_FIRST, default 1; 1 = serialize bit IN_WIDTH-1 first, 0 = bit 0 first.
REQ-003 Parameter CNT_WIDTH, default 16, width of the bit_count output.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 s_tdata  input  IN_WIDTH  input word (AXI-stream slave).
REQ-007 s_tvalid  input  1  input word valid.
REQ-008 s_tlast  input  1  input word is the last of the bitstream frame.
REQ-009 s_tready  output  1  block can accept an input word.
REQ-010 m_tdata  output  1  serial configuration bit (AXI-stream master).
REQ-011 m_tvalid  output  1  serial bit valid.
REQ-012 m_tlast  output  1  current bit is the final bit of the frame.
REQ-013 m_tready  input  1  downstream accepts the serial bit.
REQ-014 bit_count  output  CNT_WIDTH  serial bits accepted in the current/most recent frame.
REQ-015 done  output  1  one-cycle pulse after the frame's final bit is accepted.

Function
REQ-016 Transfer rules: input word accepted when s_tvalid && s_tready; serial bit accepted when m_tvalid && m_tready.
REQ-017 FSM has two states: IDLE (no word held) and SEND (word held, m_tvalid=1).
REQ-018 IDLE -> SEND on input accept; word loaded into shift register, bit index 0, s_tlast captured as held_last.
REQ-019 In SEND, each serial accept shifts the register one position toward the output end and increments the bit index.
REQ-020 m_tdata = shreg[IN_WIDTH-1] when MSB_FIRST=1, else shreg[0].
REQ-021 m_tlast = held_last && (bit index == IN_WIDTH-1); 0 otherwise.
REQ-022 While m_tvalid && !m_tready, m_tdata and m_tlast stay stable.
REQ-023 s_tready = 1 in IDLE, or in SEND when the final bit of the held word is being accepted (combinational from m_tready); 0 otherwise.
REQ-024 Final bit accepted with concurrent input accept: next word loaded same edge, FSM stays SEND, no bubble on m_tvalid.
REQ-025 Final bit accepted with no input accept: FSM -> IDLE, m_tvalid=0 next cycle.
REQ-026 s_tvalid while s_tready=0 is ignored; s_tdata not sampled.
REQ-027 bit_count increments by 1 per serial accept and saturates at 2^CNT_WIDTH-1.
REQ-028 After a tlast bit is accepted, bit_count holds its value; the first serial accept of the next frame sets it to 1.
REQ-029 done asserts for exactly one cycle, the cycle after the accept of a bit with m_tlast=1.
REQ-030 Frames without s_tlast continue indefinitely; done never asserts for them.

Reset
REQ-031 With rst high at a clock edge: FSM=IDLE, shift register=0, bit index=0, held_last=0, bit_count=0, done=0, m_tvalid=0, m_tdata=0, m_tlast=0.
REQ-032 s_tready = 0 while rst is high.
REQ-033 Reset mid-frame discards the held word; no tlast and no done are emitted for the aborted frame.
REQ-034 First input accept possible in the first cycle after rst deasserts.

Verification
REQ-035 Single word 0xA5, s_tlast=1, m_tready=1 held -> m_tdata 1,0,1,0,0,1,0,1 on 8 consecutive cycles; m_tlast only on 8th; done pulse next cycle; bit_count=8.
REQ-036 Back-to-back 0x0F then 0xF0 (tlast on second), m_tready=1 -> 16 contiguous m_tvalid cycles, bits 00001111 11110000; s_tready=1 on the 8th-bit cycle; bit_count=16.
REQ-037 0xA5 with m_tready alternating 1,0 -> data/last stable across stalls; 8 bits complete in 15 cycles; order as REQ-035.
REQ-038 MSB_FIRST=0, word 0x01, tlast -> m_tdata 1,0,0,0,0,0,0,0; m_tlast on 8th bit.
REQ-039 rst pulsed after 3 bits accepted -> next cycle m_tvalid=0, bit_count=0, done=0; s_tready=1 first cycle after rst low.
REQ-040 CNT_WIDTH=4, three words without tlast -> bit_count saturates at 15; next frame's first accept -> bit_count=1 after preceding tlast frame.
